// File: rtl/block_probe_pkg.sv
// rtl/block_probe_pkg.sv - shared framebuffer constants, probe state encoding and address mapping
package block_probe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int          FB_W   = 160;
    localparam int          FB_H   = 120;
    localparam int          ADDR_W = 15;
    localparam logic [2:0]  FB_BG  = 3'b000;

    // y*160 + x as two shifts and an add; also used by the VGA adapter wrapper
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [8:0] x, input logic [7:0] y);
        logic [ADDR_W-1:0] yy;
        yy = {7'd0, y};
        return (yy << 7) + (yy << 5) + {6'd0, x};
    endfunction

endpackage

// File: rtl/block_probe_if.sv
// rtl/block_probe_if.sv - framebuffer read port between the probe and the VGA adapter memory
interface block_probe_if;
    import block_probe_pkg::*;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);

endinterface

// File: rtl/probe_valid_pipe.sv
// rtl/probe_valid_pipe.sv - DEPTH-deep shift register tracking which read slots carry real data
module probe_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic in_valid,
    output logic out_valid
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (!resetn) sr <= '0;
                else         sr <= in_valid;
            end
        end else begin : g_many
            always_ff @(posedge clk) begin
                if (!resetn) sr <= '0;
                else         sr <= {sr[DEPTH-2:0], in_valid};
            end
        end
    endgenerate

    assign out_valid = sr[DEPTH-1];

endmodule

// File: rtl/block_probe.sv
// rtl/block_probe.sv - reads a BLK_W x BLK_H framebuffer region back and reports non-background pixels
module block_probe
    import block_probe_pkg::*;
#(
    parameter int         BLK_W     = 2,
    parameter int         BLK_H     = 4,
    parameter int         SCR_W     = FB_W,
    parameter int         SCR_H     = FB_H,
    parameter int         MEM_LAT   = 1,
    parameter logic [2:0] BG_COLOUR = FB_BG
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          go,
    input  logic [7:0]    x_in,
    input  logic [6:0]    y_in,
    block_probe_if.master fb,
    output logic          busy,
    output logic          done,
    output logic          hit,
    output logic [3:0]    hit_count,
    output logic [2:0]    hit_colour
);

    localparam int         NPIX   = BLK_W * BLK_H;
    localparam logic [3:0] P_LAST = 4'(NPIX - 1);
    localparam int         D_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [D_W-1:0] D_LAST = D_W'(MEM_LAT - 1);

    state_t            state, state_next;
    logic [3:0]        p;
    logic [D_W-1:0]    d;
    logic [7:0]        x_org;
    logic [6:0]        y_org;
    logic [8:0]        px;
    logic [7:0]        py;
    logic              in_bounds;
    logic              issue;
    logic [ADDR_W-1:0] addr_calc;
    logic [ADDR_W-1:0] addr_q;
    logic              slot_valid;

    always_comb begin
        px        = {1'b0, x_org} + 9'(32'(p) % BLK_W);
        py        = {1'b0, y_org} + 8'(32'(p) / BLK_W);
        in_bounds = (px < 9'(SCR_W)) && (py < 8'(SCR_H));
        issue     = (state == ST_ISSUE) && in_bounds;
        addr_calc = (SCR_W == FB_W) ? fb_addr(px, py)
                                    : ADDR_W'(32'(py) * SCR_W + 32'(px));
    end

    // off-screen slots leave the address bus parked on the last real read
    assign fb.rd_en   = issue;
    assign fb.rd_addr = issue ? addr_calc : addr_q;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (go) state_next = ST_ISSUE;
            ST_ISSUE: if (p == P_LAST) state_next = ST_DRAIN;
            ST_DRAIN: if (d == D_LAST) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            p          <= '0;
            d          <= '0;
            x_org      <= '0;
            y_org      <= '0;
            addr_q     <= '0;
            hit        <= 1'b0;
            hit_count  <= '0;
            hit_colour <= '0;
        end else begin
            if (issue) addr_q <= addr_calc;

            case (state)
                ST_IDLE: begin
                    if (go) begin
                        x_org <= x_in;
                        y_org <= y_in;
                        p     <= '0;
                        d     <= '0;
                    end
                end
                ST_ISSUE: p <= (p == P_LAST) ? 4'd0 : p + 4'd1;
                ST_DRAIN: d <= (d == D_LAST) ? '0 : d + D_W'(1);
                default: ;
            endcase

            if (state == ST_IDLE && go) begin
                hit        <= 1'b0;
                hit_count  <= '0;
                hit_colour <= '0;
            end else if (slot_valid && fb.rd_data != BG_COLOUR) begin
                hit       <= 1'b1;
                hit_count <= hit_count + 4'd1;
                if (!hit) hit_colour <= fb.rd_data;
            end
        end
    end

    probe_valid_pipe #(
        .DEPTH (MEM_LAT)
    ) u_valid_pipe (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (issue),
        .out_valid (slot_valid)
    );

endmodule

// File: tb/tb_block_probe.sv
// tb/tb_block_probe.sv - bench for block_probe, latency-1 and latency-3 builds side by side
module tb_block_probe;

    localparam int NPIX = 8;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       go;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic       busy0, done0, hit0, busy1, done1, hit1;
    logic [3:0] cnt0, cnt1;
    logic [2:0] col0, col1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

    block_probe_if fb0 ();
    block_probe_if fb1 ();

    block_probe #(.MEM_LAT(LAT0)) u_dut0 (
        .clk(clk), .resetn(resetn), .go(go), .x_in(x_in), .y_in(y_in), .fb(fb0),
        .busy(busy0), .done(done0), .hit(hit0), .hit_count(cnt0), .hit_colour(col0)
    );

    block_probe #(.MEM_LAT(LAT1)) u_dut1 (
        .clk(clk), .resetn(resetn), .go(go), .x_in(x_in), .y_in(y_in), .fb(fb1),
        .busy(busy1), .done(done1), .hit(hit1), .hit_count(cnt1), .hit_colour(col1)
    );

    // framebuffer; slots without a read return a non-background junk value
    logic [2:0] fb_mem [0:19199];
    logic [2:0] mp0 [0:2];
    logic [2:0] mp1 [0:2];

    always @(posedge clk) begin
        mp0[0] <= fb0.rd_en ? fb_mem[fb0.rd_addr] : 3'b101;
        mp0[1] <= mp0[0];
        mp0[2] <= mp0[1];
        mp1[0] <= fb1.rd_en ? fb_mem[fb1.rd_addr] : 3'b101;
        mp1[1] <= mp1[0];
        mp1[2] <= mp1[1];
    end

    assign fb0.rd_data = mp0[LAT0-1];
    assign fb1.rd_data = mp1[LAT1-1];

    function automatic int lat_of(int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic bit on_screen(int x, int y);
        return (x < 160) && (y < 120);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: a scan is a window of NPIX+lat+1 cycles; results come from the memory contents at go
    int m_act  [2] = '{0, 0};
    int m_j    [2] = '{0, 0};
    int m_ox   [2];
    int m_oy   [2];
    int m_cnt  [2] = '{0, 0};
    int m_col  [2] = '{0, 0};
    int m_last [2] = '{0, 0};

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                m_act[i] = 0; m_cnt[i] = 0; m_col[i] = 0; m_last[i] = 0;
            end else if (m_act[i] != 0) begin
                if (m_j[i] < NPIX) begin
                    int x, y;
                    x = m_ox[i] + m_j[i] % 2;
                    y = m_oy[i] + m_j[i] / 2;
                    if (on_screen(x, y)) m_last[i] = y * 160 + x;
                end
                if (m_j[i] == NPIX + lat_of(i)) m_act[i] = 0;
                else m_j[i]++;
            end else if (go) begin
                m_act[i] = 1; m_j[i] = 0;
                m_ox[i] = int'(x_in); m_oy[i] = int'(y_in);
                m_cnt[i] = 0; m_col[i] = 0;
                for (int q = 0; q < NPIX; q++) begin
                    int x, y;
                    x = m_ox[i] + q % 2;
                    y = m_oy[i] + q / 2;
                    if (on_screen(x, y) && fb_mem[y * 160 + x] != 3'b000) begin
                        if (m_cnt[i] == 0) m_col[i] = int'(fb_mem[y * 160 + x]);
                        m_cnt[i]++;
                    end
                end
            end
        end
    end

    task automatic cmp_dut(int i, logic re, logic [14:0] ra, logic b, logic d,
                           logic h, logic [3:0] c, logic [2:0] cl);
        int ere, era, fin;
        ere = 0;
        era = m_last[i];
        if (m_act[i] != 0 && m_j[i] < NPIX) begin
            int x, y;
            x = m_ox[i] + m_j[i] % 2;
            y = m_oy[i] + m_j[i] / 2;
            if (on_screen(x, y)) begin ere = 1; era = y * 160 + x; end
        end
        fin = (m_act[i] != 0 && m_j[i] == NPIX + lat_of(i)) ? 1 : 0;
        chk($sformatf("rd_en[%0d]", i), int'(re), ere);
        chk($sformatf("rd_addr[%0d]", i), int'(ra), era);
        chk($sformatf("busy[%0d]", i), int'(b), m_act[i]);
        chk($sformatf("done[%0d]", i), int'(d), fin);
        if (m_act[i] == 0 || fin != 0) begin
            chk($sformatf("hit[%0d]", i), int'(h), (m_cnt[i] > 0) ? 1 : 0);
            chk($sformatf("hit_count[%0d]", i), int'(c), m_cnt[i]);
            chk($sformatf("hit_colour[%0d]", i), int'(cl), m_col[i]);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            cmp_dut(0, fb0.rd_en, fb0.rd_addr, busy0, done0, hit0, cnt0, col0);
            cmp_dut(1, fb1.rd_en, fb1.rd_addr, busy1, done1, hit1, cnt1, col1);
        end
    end

    int addrq[$];

    task automatic fill_mem(logic [2:0] v);
        for (int a = 0; a < 19200; a++) fb_mem[a] = v;
    endtask

    task automatic run_scan(int x, int y, output int n0, output int n1);
        @(posedge clk);
        #1 go = 1'b1; x_in = 8'(x); y_in = 7'(y);
        @(posedge clk);
        #1 go = 1'b0;
        n0 = -1; n1 = -1;
        addrq.delete();
        for (int n = 1; n <= 40 && (n0 < 0 || n1 < 0); n++) begin
            @(negedge clk);
            if (fb0.rd_en) addrq.push_back(int'(fb0.rd_addr));
            if (done0 && n0 < 0) n0 = n;
            if (done1 && n1 < 0) n1 = n;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, dc0, dc1, f0a, f0b, f1a, f1b;
        int exp1 [8] = '{3210, 3211, 3370, 3371, 3530, 3531, 3690, 3691};

        resetn = 1'b0; go = 1'b0; x_in = '0; y_in = '0;
        fill_mem(3'b000);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1; cmp_en = 1;
        @(negedge clk);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_rd_en", int'(fb1.rd_en), 0);
        chk("rst_rd_addr", int'(fb0.rd_addr), 0);
        chk("rst_count", int'(cnt1), 0);

        // empty buffer at (10,20)
        run_scan(10, 20, n0, n1);
        chk("t1_lat0", n0, 10);
        chk("t1_lat1", n1, 12);
        chk("t1_nreads", addrq.size(), 8);
        for (int k = 0; k < 8 && k < addrq.size(); k++)
            chk($sformatf("t1_addr%0d", k), addrq[k], exp1[k]);
        chk("t1_hit", int'(hit0), 0);
        chk("t1_colour", int'(col0), 0);

        // single pixel (11,22)=100
        fb_mem[22 * 160 + 11] = 3'b100;
        run_scan(10, 20, n0, n1);
        chk("t2_model_cnt", m_cnt[0], 1);
        chk("t2_hit", int'(hit0), 1);
        chk("t2_count", int'(cnt0), 1);
        chk("t2_colour", int'(col0), 4);

        // two pixels, first in scan order wins the colour
        fill_mem(3'b000);
        fb_mem[21 * 160 + 10] = 3'b010;
        fb_mem[23 * 160 + 11] = 3'b001;
        run_scan(10, 20, n0, n1);
        chk("t3_model_col", m_col[0], 2);
        chk("t3_count", int'(cnt0), 2);
        chk("t3_colour", int'(col0), 2);
        chk("t3_colour_l3", int'(col1), 2);

        // bottom-right corner, only two pixels on screen
        fill_mem(3'b111);
        run_scan(159, 118, n0, n1);
        chk("t4_nreads", addrq.size(), 2);
        if (addrq.size() == 2) begin
            chk("t4_addr0", addrq[0], 19039);
            chk("t4_addr1", addrq[1], 19199);
        end
        chk("t4_count", int'(cnt0), 2);
        chk("t4_lat0", n0, 10);

        // last slot of the block, latency-3 build must still count it
        fill_mem(3'b000);
        fb_mem[23 * 160 + 11] = 3'b110;
        run_scan(10, 20, n0, n1);
        chk("t5_lat1", n1, 12);
        chk("t5_count_l3", int'(cnt1), 1);
        chk("t5_colour_l3", int'(col1), 6);

        // reset mid-scan, then a fresh scan elsewhere
        fill_mem(3'b101);
        @(posedge clk);
        #1 go = 1'b1; x_in = 8'd10; y_in = 7'd20;
        @(posedge clk);
        #1 go = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("t6_busy0", int'(busy0), 0);
        chk("t6_busy1", int'(busy1), 0);
        chk("t6_count0", int'(cnt0), 0);
        chk("t6_hit1", int'(hit1), 0);
        fill_mem(3'b000);
        fb_mem[50 * 160 + 41] = 3'b011;
        run_scan(40, 50, n0, n1);
        chk("t6_lat0", n0, 10);
        chk("t6_count0_b", int'(cnt0), 1);
        chk("t6_count1_b", int'(cnt1), 1);
        chk("t6_colour1_b", int'(col1), 3);

        // go pulse while busy is ignored
        fill_mem(3'b000);
        fb_mem[20 * 160 + 10] = 3'b110;
        @(posedge clk);
        #1 go = 1'b1; x_in = 8'd10; y_in = 7'd20;
        @(posedge clk);
        #1 go = 1'b0;
        repeat (3) @(posedge clk);
        #1 go = 1'b1; x_in = 8'd50; y_in = 7'd60;
        @(posedge clk);
        #1 go = 1'b0;
        dc0 = 0; dc1 = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done0) dc0++;
            if (done1) dc1++;
        end
        chk("t7_dones0", dc0, 1);
        chk("t7_dones1", dc1, 1);
        chk("t7_colour0", int'(col0), 6);

        // go held high: back-to-back scans with one idle cycle between
        @(posedge clk);
        #1 go = 1'b1; x_in = 8'd10; y_in = 7'd20;
        f0a = -1; f0b = -1; f1a = -1; f1b = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done0) begin if (f0a < 0) f0a = n; else if (f0b < 0) f0b = n; end
            if (done1) begin if (f1a < 0) f1a = n; else if (f1b < 0) f1b = n; end
        end
        #1 go = 1'b0;
        chk("t8_gap0", f0b - f0a, 11);
        chk("t8_gap1", f1b - f1a, 13);
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
